bus_ram_responder: RTL and testbench

Single-port, word-organised RAM that answers the CPU-side memory bus (`bus_addr`/`bus_wdata`/`bus_rdata`/`bus_size`/`bus_write`/`bus_pause`) as the responder, with a programmable wait-state count and byte/halfword lane steering. It sits where `mem_top` sits from an initiator's point of view, so bus masters and bus self-checkers can run against it without the full memory map. One instance covers one contiguous address region, for example IWRAM at `0x0300_0000`.

---
 rtl/bus_ram_responder.sv | 70 +++++++
 tb/tb_bus_ram_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bus_ram_responder.sv
// bus_ram_responder: wait-stated word RAM answering the CPU memory bus with byte/half lane steering.
// Define BUS_RESP_RANGE_CHECK_EN to trap out-of-range accesses instead of aliasing the region.
module bus_ram_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
  parameter int DEPTH_WORDS = 8192,
  parameter int WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [1:0]  bus_size,
  input  logic        bus_write,
  output logic [31:0] bus_rdata,
  output logic        bus_pause,
  output logic        bus_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] N = 4'(WAIT_STATES);
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  logic [31:0] mem [DEPTH_WORDS];
  logic [3:0] wcnt, be;
  logic [31:0] off, word, fmt, rd_val, wd;
  logic [AW-1:0] idx;
  logic accept, in_range, we, unused_bits;
  assign off = bus_addr - BASE_ADDR;
  assign idx = off[AW+1:2];
  assign word = mem[idx];
  assign bus_pause = wcnt != 4'd0;
  assign accept = wcnt == 4'd0 && !reset;
  assign we = accept && bus_write && in_range;
  assign unused_bits = ^{off[31:AW+2], off[1:0]};
  always_comb begin
    be = bus_size == SZ_BYTE ? 4'b0001 << bus_addr[1:0] :
         bus_size == SZ_HALF ? (bus_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd = bus_size == SZ_BYTE ? {4{bus_wdata[7:0]}} :
         bus_size == SZ_HALF ? {2{bus_wdata[15:0]}} : bus_wdata;
    fmt = bus_size == SZ_BYTE ? {24'h0, word[{bus_addr[1:0], 3'b000} +: 8]} :
          bus_size == SZ_HALF ? {16'h0, bus_addr[1] ? word[31:16] : word[15:0]} : word;
`ifdef BUS_RESP_RANGE_CHECK_EN
    in_range = off[31:AW+2] == '0;
    rd_val = in_range ? fmt : 32'hDEAD_0BAD;
`else
    in_range = 1'b1;
    rd_val = fmt;
`endif
  end
  always_ff @(posedge clock)
    if (we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  // read-first: an accepted write also returns the pre-write contents
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wcnt <= N;
      bus_rdata <= '0;
    end else if (!accept) wcnt <= wcnt - 4'd1;
    else begin
      wcnt <= N;
      bus_rdata <= rd_val;
    end
`ifdef BUS_RESP_RANGE_CHECK_EN
  always_ff @(posedge clock or posedge reset)
    if (reset) bus_err <= 1'b0;
    else if (accept && !in_range) bus_err <= 1'b1;
`else
  assign bus_err = 1'b0;
`endif
endmodule

// File: tb/tb_bus_ram_responder.sv
// tb_bus_ram_responder: checks a zero-wait and a three-wait instance against a byte-level memory model.
module tb_bus_ram_responder;
  localparam logic [31:0] BASE = 32'h0300_0000;
  localparam int unsigned REG = 32768;
  localparam logic [1:0] SB = 2'd0, SH = 2'd1, SW = 2'd2;
`ifdef BUS_RESP_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [1:0] size [2];
  logic wr [2];
  logic [31:0] rdata [2];
  logic pause [2];
  logic err [2];
  int vectors = 0, miscompares = 0;
  logic [7:0] mb [int unsigned];
  bit err_exp [2];
  bit last_ok [2];
  logic [31:0] last [2];

  always #5 clk = ~clk;

  bus_ram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(8192), .WAIT_STATES(0)) u0 (
    .clock(clk), .reset(rst[0]), .bus_addr(addr[0]), .bus_wdata(wdata[0]), .bus_size(size[0]),
    .bus_write(wr[0]), .bus_rdata(rdata[0]), .bus_pause(pause[0]), .bus_err(err[0]));
  bus_ram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(8192), .WAIT_STATES(3)) u3 (
    .clock(clk), .reset(rst[1]), .bus_addr(addr[1]), .bus_wdata(wdata[1]), .bus_size(size[1]),
    .bus_write(wr[1]), .bus_rdata(rdata[1]), .bus_pause(pause[1]), .bus_err(err[1]));

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(logic [31:0] a);
    return !RC || (a - BASE) < REG;
  endfunction

  function automatic int unsigned key(int s, logic [31:0] a);
    return s * REG + ((a - BASE) % REG);
  endfunction

  function automatic int span(logic [1:0] sz);
    return sz == SB ? 1 : sz == SH ? 2 : 4;
  endfunction

  function automatic bit mdl_read(int s, logic [1:0] sz, logic [31:0] a, output logic [31:0] v);
    int n = span(sz);
    logic [31:0] st = a & ~32'(n - 1);
    v = '0;
    if (!in_rng(a)) begin
      v = 32'hDEAD_0BAD;
      return 1'b1;
    end
    for (int i = 0; i < n; i++) begin
      if (!mb.exists(key(s, st + 32'(i)))) return 1'b0;
      v[8*i +: 8] = mb[key(s, st + 32'(i))];
    end
    return 1'b1;
  endfunction

  task automatic mdl_write(int s, logic [1:0] sz, logic [31:0] a, logic [31:0] d);
    int n = span(sz);
    logic [31:0] st = a & ~32'(n - 1);
    if (!in_rng(a)) return;
    for (int i = 0; i < n; i++) mb[key(s, st + 32'(i))] = d[8*i +: 8];
  endtask

  task automatic do_reset(int s);
    rst[s] = 1'b1;
    @(posedge clk); #1;
    check("rst/pause", 32'(pause[s]), 32'(s == 1));
    check("rst/rdata", rdata[s], 32'h0);
    check("rst/err", 32'(err[s]), 32'h0);
    rst[s] = 1'b0;
    last[s] = '0;
    last_ok[s] = 1'b1;
    err_exp[s] = 1'b0;
  endtask

  task automatic access(int s, bit w, logic [1:0] sz, logic [31:0] a, logic [31:0] d, string tag, int stalls_exp);
    logic [31:0] exp;
    bit ok;
    int stalls = 0;
    @(negedge clk);
    addr[s] = a; wdata[s] = d; size[s] = sz; wr[s] = w;
    ok = mdl_read(s, sz, a, exp);
    if (w && !in_rng(a)) ok = 1'b0;
    if (!in_rng(a)) err_exp[s] = 1'b1;
    if (w) mdl_write(s, sz, a, d);
    for (int t = 0; t < 20 && pause[s] !== 1'b0; t++) begin
      stalls++;
      @(posedge clk); #1;
      if (last_ok[s]) check({tag, "/hold"}, rdata[s], last[s]);
      @(negedge clk);
    end
    @(posedge clk); #1;
    check({tag, "/stalls"}, 32'(stalls), 32'(stalls_exp));
    check({tag, "/err"}, 32'(err[s]), 32'(err_exp[s]));
    if (ok) check(tag, rdata[s], exp);
    last[s] = exp;
    last_ok[s] = ok;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; addr[s] = BASE; wdata[s] = '0; size[s] = SW; wr[s] = 1'b0;
    end
    do_reset(0);
    do_reset(1);
    access(0, 1, SW, BASE, 32'hDEAD_BEEF, "w0", 0);
    access(0, 0, SW, BASE, 32'h0, "r0", 0);
    access(0, 1, SW, BASE + 4, 32'h1122_3344, "w4", 0);
    access(0, 1, SB, BASE + 5, 32'h0000_00AA, "b5", 0);
    access(0, 0, SW, BASE + 4, 32'h0, "r4", 0);
    access(0, 0, SB, BASE + 7, 32'h0, "rb7", 0);
    access(0, 1, SW, BASE + 32'h10, 32'h0, "w10", 0);
    access(0, 1, SH, BASE + 32'h12, 32'h0000_BEEF, "h12", 0);
    access(0, 0, SW, BASE + 32'h10, 32'h0, "r10", 0);
    access(0, 0, SH, BASE + 32'h13, 32'h0, "rh13", 0);
`ifdef BUS_RESP_RANGE_CHECK_EN
    access(0, 1, SW, 32'h0500_0000, 32'h1234_5678, "oor_w", 0);
    access(0, 0, SW, 32'h0500_0000, 32'h0, "oor_r", 0);
    access(0, 0, SW, BASE, 32'h0, "oor_keep", 0);
    access(0, 0, SW, BASE - 4, 32'h0, "oor_below", 0);
`else
    access(0, 1, SW, BASE + 32'h8000, 32'h5A5A_C3C3, "alias_w", 0);
    access(0, 0, SW, BASE, 32'h0, "alias_r", 0);
`endif
    access(1, 1, SW, BASE + 32'h20, 32'h1111_1111, "n3_w20", 3);
    access(1, 1, SW, BASE + 32'h24, 32'h2222_2222, "n3_w24", 3);
    for (int k = 0; k < 4; k++) access(1, 0, SW, BASE + 32'h20 + 32'(4 * (k % 2)), 32'h0, "n3_r", 3);
    @(negedge clk);
    addr[1] = BASE + 32'h20; wdata[1] = 32'hCAFE_F00D; size[1] = SW; wr[1] = 1'b1;
    check("mid/pause0", 32'(pause[1]), 32'h1);
    @(negedge clk);
    check("mid/pause1", 32'(pause[1]), 32'h1);
    rst[1] = 1'b1;
    #1;
    check("mid/rdata", rdata[1], 32'h0);
    wr[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    last[1] = '0;
    last_ok[1] = 1'b1;
    access(1, 0, SW, BASE + 32'h20, 32'h0, "mid_r", 3);
    for (int i = 0; i < 16; i++) access(0, 1, SW, BASE + 32'h100 + 32'(4 * i), $urandom, "rinit", 0);
    for (int k = 0; k < 60; k++) begin
      a = BASE + 32'h100 + 32'($urandom_range(63));
`ifdef BUS_RESP_RANGE_CHECK_EN
      if ($urandom_range(7) == 0) a = a + 32'h0100_0000;
`else
      a = a + 32'($urandom_range(3)) * REG;
`endif
      access(0, 1'($urandom_range(1)), 2'($urandom_range(2)), a, $urandom, "rand0", 0);
    end
    for (int k = 0; k < 8; k++)
      access(1, 1'($urandom_range(1)), 2'($urandom_range(2)), BASE + 32'h20 + 32'($urandom_range(7)), $urandom, "rand3", 3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
